// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage and the data memory controller.
interface data_memory_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_byteen;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_byteen,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_byteen,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory with valid/ready requests, a fixed
// response latency, byte-lane enables and misaligned/out-of-range reporting.
// One request is outstanding at a time: IDLE -> (BUSY) -> RESP -> IDLE.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clock_enable,
    data_memory_ctrl_if.slave     bus
);
    localparam int                    IDX_W    = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(DEPTH_BYTES - 4);
    localparam logic [3:0]            LAT_M1   = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_write;
    logic             r_err;
    logic [IDX_W-3:0] r_word;
    logic [3:0]       r_byteen;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_error;

    // Storage is not reset; it powers up cleared.
    logic [7:0]       r_mem [0:DEPTH_BYTES-1] = '{default: 8'h00};

    logic             w_accept;
    logic             w_err;
    logic [IDX_W-3:0] w_word;
    logic [IDX_W-3:0] w_ld_word;
    logic [3:0]       w_ld_ben;
    logic             w_ld_err;
    logic             w_ld_write;
    logic [31:0]      w_ld_data;
    logic [31:0]      w_rsp_data;

    assign bus.req_ready = (r_state == IDLE) && reset;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_err         = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > MAX_ADDR);
    assign w_word        = bus.req_addr[IDX_W-1:2];

    // With READ_LATENCY == 1 the response is built straight from the request
    // being accepted; otherwise from the latched copy.
    assign w_ld_word  = (r_state == IDLE) ? w_word           : r_word;
    assign w_ld_ben   = (r_state == IDLE) ? bus.req_byteen   : r_byteen;
    assign w_ld_err   = (r_state == IDLE) ? w_err            : r_err;
    assign w_ld_write = (r_state == IDLE) ? bus.req_write    : r_write;

    // Assemble the loaded word big-endian; disabled lanes read as zero.
    always_comb begin
        w_ld_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_ld_ben[3-i])
                w_ld_data[31-8*i -: 8] = r_mem[{w_ld_word, 2'(i)}];
        end
    end

    assign w_rsp_data = (w_ld_write || w_ld_err) ? 32'h0 : w_ld_data;

    // Commit stores at the acceptance edge, one byte per enabled lane.
    always_ff @(posedge clk) begin
        if (clock_enable && w_accept && bus.req_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_byteen[3-i])
                    r_mem[{w_word, 2'(i)}] <= bus.req_wdata[31-8*i -: 8];
            end
        end
    end

    // Request sequencing and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (clock_enable) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= bus.req_write;
                        r_err    <= w_err;
                        r_word   <= w_word;
                        r_byteen <= bus.req_byteen;
                        if (READ_LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_data;
                            r_rsp_error <= w_err;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_data;
                        r_rsp_error <= r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_error <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;
endmodule
